// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left/right, rotate left/right,
// parallel load and synchronous clear, with a shift-event counter that
// either saturates at WIDTH or wraps to zero, and a one-cycle wordDone
// pulse marking the completion of a full word of shift events.
//
// Interface handshake: there is no valid/ready pair. The only qualifier
// is enable, sampled on every rising clk edge; with enable low, every
// piece of state holds and wordDone reads 0 in the following cycle.
module universal_shift_reg #(
  parameter int WIDTH        = 8,
  parameter int AUTO_RESTART = 0,
  localparam int CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clrN,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             serialInLsb,
  input  logic             serialInMsb,
  input  logic [WIDTH-1:0] parallelInput,
  output logic [WIDTH-1:0] parallelOutput,
  output logic             serialOutMsb,
  output logic             serialOutLsb,
  output logic [CNT_W-1:0] shiftCount,
  output logic             wordDone
);

  // Operation encoding carried on the mode input.
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  // Counter landmarks: the last count before a word completes, and the
  // saturation value used when the counter does not wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_evt;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // Data-path next state: pick the operation and flag shift/rotate events.
  always_comb begin
    q_d       = q_q;
    shift_evt = 1'b0;
    if (enable) begin
      case (mode_sel)
        MODE_SHL: begin
          q_d       = {q_q[WIDTH-2:0], serialInLsb};
          shift_evt = 1'b1;
        end
        MODE_SHR: begin
          q_d       = {serialInMsb, q_q[WIDTH-1:1]};
          shift_evt = 1'b1;
        end
        MODE_ROL: begin
          q_d       = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shift_evt = 1'b1;
        end
        MODE_ROR: begin
          q_d       = {q_q[0], q_q[WIDTH-1:1]};
          shift_evt = 1'b1;
        end
        MODE_LOAD: q_d = parallelInput;
        MODE_CLR:  q_d = '0;
        MODE_HOLD: q_d = q_q;
        MODE_RSVD: q_d = q_q;
        default:   q_d = q_q;
      endcase
    end
  end

  // Counter and word-complete next state. Load/clear restart the word and
  // never pulse; a shift from the last count completes the word.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (enable && (mode_sel == MODE_LOAD || mode_sel == MODE_CLR)) begin
      cnt_d = '0;
    end else if (shift_evt) begin
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
        cnt_d  = (AUTO_RESTART != 0) ? '0 : CNT_FULL;
      end else if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers; clrN clears everything immediately, abandoning any word.
  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Every output is taken straight from a register, never from an input.
  assign parallelOutput = q_q;
  assign serialOutMsb   = q_q[WIDTH-1];
  assign serialOutLsb   = q_q[0];
  assign shiftCount     = cnt_q;
  assign wordDone       = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg at WIDTH=4. Two instances share all inputs:
// dut0 saturates its counter, dut1 wraps it.
module tb_universal_shift_reg;

  localparam int W  = 4;
  localparam int CW = 3;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          clrN;
  logic          enable;
  logic [2:0]    mode;
  logic          sl, sm;
  logic [W-1:0]  pin;
  logic [W-1:0]  po0, po1;
  logic          msb0, msb1, lsb0, lsb1;
  logic [CW-1:0] cnt0, cnt1;
  logic          wd0, wd1;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(W), .AUTO_RESTART(0)) dut0 (
    .clk(clk), .clrN(clrN), .enable(enable), .mode(mode),
    .serialInLsb(sl), .serialInMsb(sm), .parallelInput(pin),
    .parallelOutput(po0), .serialOutMsb(msb0), .serialOutLsb(lsb0),
    .shiftCount(cnt0), .wordDone(wd0)
  );

  universal_shift_reg #(.WIDTH(W), .AUTO_RESTART(1)) dut1 (
    .clk(clk), .clrN(clrN), .enable(enable), .mode(mode),
    .serialInLsb(sl), .serialInMsb(sm), .parallelInput(pin),
    .parallelOutput(po1), .serialOutMsb(msb1), .serialOutLsb(lsb1),
    .shiftCount(cnt1), .wordDone(wd1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The word is a plain integer 0..15; mn counts shift events since the
  // last load/clear/reset without any bound.
  int unsigned mq;
  int unsigned mn;
  bit          mdone0, mdone1;

  task automatic model_reset();
    mq = 0; mn = 0; mdone0 = 0; mdone1 = 0;
  endtask

  task automatic model_apply(input logic en, input logic [2:0] md,
                             input logic bl, input logic bm, input logic [W-1:0] pi);
    int unsigned t;
    bit shifted;
    t = mq; shifted = 0;
    mdone0 = 0; mdone1 = 0;
    if (en) begin
      case (md)
        3'd1: begin mq = (t * 2 + bl) % 16;        shifted = 1; end
        3'd2: begin mq = t / 2 + bm * 8;           shifted = 1; end
        3'd3: begin mq = (t * 2) % 16 + t / 8;     shifted = 1; end
        3'd4: begin mq = t / 2 + (t % 2) * 8;      shifted = 1; end
        3'd5: begin mq = pi; mn = 0; end
        3'd6: begin mq = 0;  mn = 0; end
        default: ;
      endcase
      if (shifted) begin
        mn++;
        mdone0 = (mn == 4);
        mdone1 = (mn % 4 == 0);
      end
    end
  endtask

  function automatic int unsigned exp_cnt0();
    return (mn > 4) ? 4 : mn;
  endfunction

  task automatic check_dut0_model(input string tag);
    check({tag, " dut0 q"},    po0,  mq);
    check({tag, " dut0 msb"},  msb0, (mq / 8) % 2);
    check({tag, " dut0 lsb"},  lsb0, mq % 2);
    check({tag, " dut0 cnt"},  cnt0, exp_cnt0());
    check({tag, " dut0 done"}, wd0,  mdone0);
  endtask

  task automatic check_dut1_model(input string tag);
    check({tag, " dut1 q"},    po1,  mq);
    check({tag, " dut1 msb"},  msb1, (mq / 8) % 2);
    check({tag, " dut1 lsb"},  lsb1, mq % 2);
    check({tag, " dut1 cnt"},  cnt1, mn % 4);
    check({tag, " dut1 done"}, wd1,  mdone1);
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs, advance the model, take one edge, sample 1 time unit later.
  task automatic step(input logic en, input logic [2:0] md,
                      input logic bl, input logic bm, input logic [W-1:0] pi);
    enable = en; mode = md; sl = bl; sm = bm; pin = pi;
    model_apply(en, md, bl, bm, pi);
    @(posedge clk);
    #1;
  endtask

  // Assert clrN between edges, check zeros before the next edge, release.
  task automatic mid_cycle_reset(input string tag);
    #3;
    clrN = 1'b0;
    #1;
    model_reset();
    check({tag, " rst q0"},    po0,  0);
    check({tag, " rst cnt0"},  cnt0, 0);
    check({tag, " rst done0"}, wd0,  0);
    check({tag, " rst q1"},    po1,  0);
    check({tag, " rst cnt1"},  cnt1, 0);
    check({tag, " rst msb0"},  msb0, 0);
    check({tag, " rst lsb0"},  lsb0, 0);
    @(negedge clk);
    clrN = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          en;
    logic [2:0]    md;
    logic          bl;
    logic          bm;
    logic [W-1:0]  pi;
    logic [W-1:0]  exp_q;
    logic [CW-1:0] exp_cnt;
    logic          exp_done;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic en, input logic [2:0] md, input logic bl,
                              input logic bm, input logic [W-1:0] pi,
                              input logic [W-1:0] eq, input logic [CW-1:0] ec,
                              input logic ed);
    vec_t v;
    v.en = en; v.md = md; v.bl = bl; v.bm = bm; v.pi = pi;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    logic [W-1:0] eq;
    logic [CW-1:0] seq_cnt [8];
    logic          seq_done [8];
    clrN = 1'b0; enable = 1'b0; mode = 3'd0; sl = 1'b0; sm = 1'b0; pin = '0;
    model_reset();
    #12;
    check("reset q0",    po0,  0);
    check("reset cnt0",  cnt0, 0);
    check("reset done0", wd0,  0);
    check("reset q1",    po1,  0);
    @(negedge clk);
    clrN = 1'b1;

    // Load 1011 then four shift-lefts with 0 entering.
    vt.push_back(mk(1, 3'd5, 0, 0, 4'b1011, 4'b1011, 0, 0));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b0110, 1, 0));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b1100, 2, 0));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b1000, 3, 0));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b0000, 4, 1));
    vt.push_back(mk(1, 3'd0, 0, 0, 4'b0000, 4'b0000, 4, 0));
    // Load 1011 then four rotate-rights back to 1011.
    vt.push_back(mk(1, 3'd5, 0, 0, 4'b1011, 4'b1011, 0, 0));
    vt.push_back(mk(1, 3'd4, 0, 0, 4'b0000, 4'b1101, 1, 0));
    vt.push_back(mk(1, 3'd4, 0, 0, 4'b0000, 4'b1110, 2, 0));
    vt.push_back(mk(1, 3'd4, 0, 0, 4'b0000, 4'b0111, 3, 0));
    vt.push_back(mk(1, 3'd4, 0, 0, 4'b0000, 4'b1011, 4, 1));
    // Sync clear then deserialise 1,0,0,1 via shift-right.
    vt.push_back(mk(1, 3'd6, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk(1, 3'd2, 0, 1, 4'b0000, 4'b1000, 1, 0));
    vt.push_back(mk(1, 3'd2, 0, 0, 4'b0000, 4'b0100, 2, 0));
    vt.push_back(mk(1, 3'd2, 0, 0, 4'b0000, 4'b0010, 3, 0));
    vt.push_back(mk(1, 3'd2, 0, 1, 4'b0000, 4'b1001, 4, 1));
    // Load 1100, two shifts, then enable low for three cycles.
    vt.push_back(mk(1, 3'd5, 0, 0, 4'b1100, 4'b1100, 0, 0));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b1000, 1, 0));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b0000, 2, 0));
    vt.push_back(mk(0, 3'd1, 1, 1, 4'b1111, 4'b0000, 2, 0));
    vt.push_back(mk(0, 3'd1, 1, 1, 4'b1111, 4'b0000, 2, 0));
    vt.push_back(mk(0, 3'd1, 1, 1, 4'b1111, 4'b0000, 2, 0));
    // Saturation: data keeps moving, count stays at 4, no extra pulse.
    vt.push_back(mk(1, 3'd1, 1, 0, 4'b0000, 4'b0001, 3, 0));
    vt.push_back(mk(1, 3'd1, 1, 0, 4'b0000, 4'b0011, 4, 1));
    vt.push_back(mk(1, 3'd1, 0, 0, 4'b0000, 4'b0110, 4, 0));
    vt.push_back(mk(1, 3'd7, 1, 1, 4'b1111, 4'b0110, 4, 0));
    vt.push_back(mk(1, 3'd3, 0, 0, 4'b0000, 4'b1100, 4, 0));
    // Load at count 3 restarts the word without a pulse.
    vt.push_back(mk(1, 3'd5, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk(1, 3'd1, 1, 0, 4'b0000, 4'b0001, 1, 0));
    vt.push_back(mk(1, 3'd1, 1, 0, 4'b0000, 4'b0011, 2, 0));
    vt.push_back(mk(1, 3'd1, 1, 0, 4'b0000, 4'b0111, 3, 0));
    vt.push_back(mk(1, 3'd5, 0, 0, 4'b1010, 4'b1010, 0, 0));
    // Clear at count 3 likewise; disabled load ignores parallelInput.
    vt.push_back(mk(1, 3'd3, 0, 0, 4'b0000, 4'b0101, 1, 0));
    vt.push_back(mk(1, 3'd3, 0, 0, 4'b0000, 4'b1010, 2, 0));
    vt.push_back(mk(1, 3'd3, 0, 0, 4'b0000, 4'b0101, 3, 0));
    vt.push_back(mk(1, 3'd6, 0, 0, 4'b1111, 4'b0000, 0, 0));
    vt.push_back(mk(0, 3'd5, 0, 0, 4'b1111, 4'b0000, 0, 0));

    foreach (vt[i]) begin
      v = vt[i];
      step(v.en, v.md, v.bl, v.bm, v.pi);
      eq = v.exp_q;
      check($sformatf("vec%0d q", i),    po0,  v.exp_q);
      check($sformatf("vec%0d msb", i),  msb0, eq[W-1]);
      check($sformatf("vec%0d lsb", i),  lsb0, eq[0]);
      check($sformatf("vec%0d cnt", i),  cnt0, v.exp_cnt);
      check($sformatf("vec%0d done", i), wd0,  v.exp_done);
      check_dut1_model($sformatf("vec%0d", i));
    end

    // Wrapping counter over eight shift-lefts.
    mid_cycle_reset("wrap");
    seq_cnt  = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    seq_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd1, i[0], 0, 4'b0000);
      check($sformatf("wrap%0d cnt1", i),  cnt1, seq_cnt[i]);
      check($sformatf("wrap%0d done1", i), wd1,  seq_done[i]);
    end

    // Three shifts, reset between edges, then first edge after release acts.
    step(1, 3'd5, 0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1, 3'd1, 1, 0, 4'b0000);
    check("pre-rst cnt0", cnt0, 3);
    mid_cycle_reset("mid");
    step(1, 3'd5, 0, 0, 4'b1011);
    check("post-rst q0",   po0, 4'b1011);
    check("post-rst cnt0", cnt0, 0);
    step(1, 3'd0, 0, 0, 4'b0000);
    check("post-rst done0", wd0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        mid_cycle_reset("rnd");
      end else begin
        step($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
        check_dut0_model($sformatf("rnd%0d", i));
        check_dut1_model($sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2 to 64).
REQ-002 The block SHALL provide parameter AUTO_RESTART, default 0, with the following settings:
- 0: shift counter saturates at WIDTH.
- 1: shift counter wraps to 0 on reaching WIDTH.
REQ-003 The block SHALL derive localparam CNT_W = $clog2(WIDTH+1) for the counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 clrN  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  operation qualifier; when low, all state holds.
REQ-007 mode  input  3  operation select, per REQ-012.
REQ-008 serialInLsb  input  1  bit entering bit 0 on shift-left.
REQ-009 serialInMsb  input  1  bit entering bit WIDTH-1 on shift-right.
REQ-010 parallelInput  input  WIDTH  load data.
REQ-011 The block SHALL provide the following outputs:
- parallelOutput  output  WIDTH  register contents q.
- serialOutMsb  output  1  q[WIDTH-1], combinational from q.
- serialOutLsb  output  1  q[0], combinational from q.
- shiftCount  output  CNT_W  shifts since last load/clear.
- wordDone  output  1  registered one-cycle pulse, per REQ-016.

Function
REQ-012 With enable=1, mode SHALL select one of the following operations:
- 000: hold.
- 001: shift left (q <= {q[WIDTH-2:0], serialInLsb}).
- 010: shift right (q <= {serialInMsb, q[WIDTH-1:1]}).
- 011: rotate left (q <= {q[WIDTH-2:0], q[WIDTH-1]}).
- 100: rotate right (q <= {q[0], q[WIDTH-1:1]}).
- 101: parallel load (q <= parallelInput).
- 110: synchronous clear (q <= 0).
- 111: reserved; behaves as hold.
REQ-013 With enable=0, q and shiftCount SHALL hold and wordDone SHALL be 0 the next cycle, regardless of mode.
REQ-014 Each enabled shift or rotate (modes 001-100) SHALL count as one shift event.
REQ-015 On each shift event, shiftCount SHALL advance as follows:
- Below WIDTH-1: increment by 1.
- Equal to WIDTH-1, AUTO_RESTART=0: go to WIDTH and saturate there.
- Equal to WIDTH-1, AUTO_RESTART=1: go to 0.
REQ-016 wordDone SHALL be 1 for exactly the cycle after a shift event moves shiftCount from WIDTH-1 to its next value; otherwise it SHALL be 0.
REQ-017 With AUTO_RESTART=0 and shiftCount=WIDTH, further shift events SHALL continue to move q but SHALL NOT change shiftCount or pulse wordDone.
REQ-018 Enabled load (101) or clear (110) SHALL set shiftCount to 0 and SHALL NOT pulse wordDone, even when shiftCount=WIDTH-1.
REQ-019 Modes are mutually exclusive per cycle, so no simultaneous-operation priority is required.
REQ-020 parallelInput SHALL be sampled only on an enabled load edge.
REQ-021 There SHALL be no combinational path from any input to any output; serial outputs derive from q only.

Reset
REQ-022 clrN low SHALL immediately, without waiting for clk, force q=0, shiftCount=0 and wordDone=0.
REQ-023 clrN low mid-word SHALL abandon the word with no wordDone pulse.
REQ-024 The first operation after clrN deasserts SHALL take effect on the first rising clk edge at which clrN is high.
REQ-025 The synchronous clear (mode 110) SHALL be functionally identical to reset except for timing.

Verification (WIDTH=4 unless stated)
REQ-026 Scenario: load 1011, then 4x shift-left with serialInLsb=0.
- parallelOutput SHALL be 0110, 1100, 1000, 0000.
- serialOutMsb before each shift SHALL be 1, 0, 1, 1.
- shiftCount SHALL be 1, 2, 3, 4.
- wordDone SHALL be high only in the cycle after the 4th shift.
REQ-027 Scenario: load 1011, then 4x rotate-right.
- serialOutLsb SHALL be 1, 1, 0, 1.
- Final parallelOutput SHALL be 1011.
- wordDone SHALL pulse once.
REQ-028 Scenario: shift-right 4x from reset with serialInMsb sequence 1, 0, 0, 1.
- parallelOutput SHALL be 1001 (deserialise).
- wordDone SHALL pulse once.
REQ-029 Scenario: load 1100, 2x shift-left, drop enable for 3 cycles while mode=001.
- q SHALL hold at 0000.
- shiftCount SHALL hold at 2.
- wordDone SHALL be 0.
REQ-030 Scenario: AUTO_RESTART=1, 8 consecutive shift-left events.
- shiftCount SHALL be 1, 2, 3, 0, 1, 2, 3, 0.
- wordDone SHALL pulse after the 4th and 8th shifts.
REQ-031 Scenario: 3 shifts, then assert clrN low between clock edges.
- Outputs SHALL go to zero before the next edge.
- A load at shiftCount=3 SHALL give shiftCount=0 with no wordDone.
